conv_table_loader: RTL and testbench

Run-time writer for a synchronous lookup table: accepts a stream of DATA-bit words over a valid/ready handshake and writes them to consecutive addresses of an internal block RAM, starting at address 0. Consumers read the table through a registered read port with the same one-cycle latency and addressing as the file-initialised lookup ROMs. Replaces a fixed conversion table when the table must be reloaded without resynthesis.

---
 rtl/conv_loader_pkg.sv | 17 +
 rtl/synch_RAM_dp.sv | 48 ++++
 rtl/conv_table_loader.sv | 140 ++++++++++++++
 tb/tb_conv_table_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_loader_pkg.sv
// Shared types and helpers for the run-time conversion table loader.
//   state_t : loader FSM states (IDLE, LOAD, DONE)
//   depth() : number of table entries for a given address width
package conv_loader_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   // Table depth for an address width of addr_w bits (2**addr_w).
   function automatic int unsigned depth(input int unsigned addr_w);
      return 32'(1) << addr_w;
   endfunction

endpackage : conv_loader_pkg

// File: rtl/synch_RAM_dp.sv
// Simple dual-port block RAM: one write port, one registered read-first read port.
// Ports:
//   clk      : clock, all logic on rising edge
//   reset_n  : synchronous active-low reset (read register only, array untouched)
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : registered read data, one cycle after rd_addr
module synch_RAM_dp
   import conv_loader_pkg::*;
#(
   parameter int unsigned DATA = 2,
   parameter int unsigned ADDR = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            wr_en,
   input  logic [ADDR-1:0] wr_addr,
   input  logic [DATA-1:0] wr_data,
   input  logic [ADDR-1:0] rd_addr,
   output logic [DATA-1:0] rd_data
);

   localparam int unsigned DEPTH = depth(ADDR);

   (* ram_style = "block" *) logic [DATA-1:0] r_mem [DEPTH];
   logic [DATA-1:0] r_rd_data;

   // Write port; contents are never cleared so a reload only overwrites.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   // Read port; nonblocking update gives read-first on a same-address collision.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= r_mem[rd_addr];
      end
   end

   assign rd_data = r_rd_data;

endmodule : synch_RAM_dp

// File: rtl/conv_table_loader.sv
// Run-time writer for a lookup table: streams words over valid/ready into
// consecutive RAM addresses from 0; consumers read through a registered port.
// Optional feature macro: CONV_LOADER_CHECKSUM_EN (adds XOR checksum output).
// Ports:
//   clk       : clock
//   reset_n   : synchronous active-low reset
//   start     : begin/restart a load at address 0
//   wr_valid  : wr_data valid
//   wr_data   : word to write
//   wr_ready  : word accepted this cycle when wr_valid
//   rd_addr   : read address
//   rd_data   : registered read data
//   busy      : load in progress
//   done      : table completely loaded
//   count     : words written in current or last load
//   checksum  : XOR of accepted words (CONV_LOADER_CHECKSUM_EN only)
module conv_table_loader
   import conv_loader_pkg::*;
#(
   parameter int unsigned DATA = 2,
   parameter int unsigned ADDR = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            wr_valid,
   input  logic [DATA-1:0] wr_data,
   output logic            wr_ready,
   input  logic [ADDR-1:0] rd_addr,
   output logic [DATA-1:0] rd_data,
   output logic            busy,
   output logic            done,
`ifdef CONV_LOADER_CHECKSUM_EN
   output logic [DATA-1:0] checksum,
`endif
   output logic [ADDR:0]   count
);

   localparam int unsigned CW = ADDR + 1;
   localparam logic [CW-1:0] FULL = CW'(depth(ADDR));

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_count_nxt;
   logic            w_wr_en;
   logic            r_wr_ready;
   logic            r_busy;
   logic            r_done;

   // State register and registered status decodes of the next state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_wr_ready <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_count    <= w_count_nxt;
         r_wr_ready <= (w_state_nxt == LOAD);
         r_busy     <= (w_state_nxt == LOAD);
         r_done     <= (w_state_nxt == DONE);
      end
   end

   // Next-state, counter and write strobe; start outranks a same-cycle transfer.
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_wr_en     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = LOAD;
               w_count_nxt = '0;
            end
         end
         LOAD: begin
            if (start) begin
               w_count_nxt = '0;
            end else if (wr_valid) begin
               w_wr_en     = 1'b1;
               w_count_nxt = r_count + CW'(1);
               if ((r_count + CW'(1)) == FULL) begin
                  w_state_nxt = DONE;
               end
            end
         end
         DONE: begin
            if (start) begin
               w_state_nxt = LOAD;
               w_count_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
         end
      endcase
   end

   // Table storage; write address is the low bits of the word counter.
   synch_RAM_dp #(
      .DATA (DATA),
      .ADDR (ADDR)
   ) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (w_wr_en),
      .wr_addr (r_count[ADDR-1:0]),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

`ifdef CONV_LOADER_CHECKSUM_EN
   logic [DATA-1:0] r_checksum;

   // XOR of every accepted word since the last start.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_checksum <= '0;
      end else if (start) begin
         r_checksum <= '0;
      end else if (w_wr_en) begin
         r_checksum <= r_checksum ^ wr_data;
      end
   end

   assign checksum = r_checksum;
`endif

   assign wr_ready = r_wr_ready;
   assign busy     = r_busy;
   assign done     = r_done;
   assign count    = r_count;

endmodule : conv_table_loader

// File: tb/tb_conv_table_loader.sv
// Directed self-checking bench for conv_table_loader (DATA=2, ADDR=2).
module tb_conv_table_loader;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic       wr_valid;
   logic [1:0] wr_data;
   logic       wr_ready;
   logic [1:0] rd_addr;
   logic [1:0] rd_data;
   logic       busy;
   logic       done;
   logic [2:0] count;
`ifdef CONV_LOADER_CHECKSUM_EN
   logic [1:0] checksum;
`endif

   int errors = 0;
   int checks = 0;

   conv_table_loader #(
      .DATA (2),
      .ADDR (2)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .busy     (busy),
      .done     (done),
`ifdef CONV_LOADER_CHECKSUM_EN
      .checksum (checksum),
`endif
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] load_a   [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
   int         vld_pat  [7] = '{1, 0, 0, 1, 1, 0, 1};
   int         cnt_pat  [7] = '{1, 1, 1, 2, 3, 3, 4};
   logic [1:0] load_c   [4] = '{2'd3, 2'd3, 2'd3, 2'd1};

   initial begin
      int k;
      reset_n  = 1'b0;
      start    = 1'b0;
      wr_valid = 1'b1;
      wr_data  = 2'd3;
      rd_addr  = 2'd0;
      tick();
      tick();
      chk("rst_wr_ready", 32'(wr_ready), 0);
      chk("rst_busy",     32'(busy),     0);
      chk("rst_done",     32'(done),     0);
      chk("rst_count",    32'(count),    0);
      chk("rst_rd_data",  32'(rd_data),  0);

      // Idle with wr_valid high: nothing happens.
      reset_n = 1'b1;
      tick();
      chk("idle_count",    32'(count),    0);
      chk("idle_wr_ready", 32'(wr_ready), 0);

      // Full back-to-back load 3,2,1,0.
      wr_valid = 1'b0;
      start    = 1'b1;
      tick();
      start = 1'b0;
      chk("ld1_busy",     32'(busy),     1);
      chk("ld1_wr_ready", 32'(wr_ready), 1);
      chk("ld1_count0",   32'(count),    0);
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1;
         wr_data  = load_a[i];
         tick();
         chk("ld1_count", 32'(count), 32'(i + 1));
      end
      chk("ld1_done",     32'(done),     1);
      chk("ld1_busy_lo",  32'(busy),     0);
      chk("ld1_ready_lo", 32'(wr_ready), 0);
`ifdef CONV_LOADER_CHECKSUM_EN
      chk("ld1_checksum", 32'(checksum), 0);
`endif
      wr_data = 2'd3;
      tick();
      chk("ld1_hold_count", 32'(count), 4);
      chk("ld1_hold_done",  32'(done),  1);
      wr_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rd_addr = 2'(i);
         tick();
         chk("ld1_read", 32'(rd_data), 32'(load_a[i]));
      end

      // Gapped load 0,1,2,3 with valid pattern 1,0,0,1,1,0,1.
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      for (int i = 0; i < 7; i++) begin
         wr_valid = (vld_pat[i] != 0);
         wr_data  = (vld_pat[i] != 0) ? 2'(k) : 2'd3;
         if (vld_pat[i] != 0) k++;
         tick();
         chk("bp_count", 32'(count), 32'(cnt_pat[i]));
      end
      chk("bp_ready_lo", 32'(wr_ready), 0);
      chk("bp_done",     32'(done),     1);
      wr_valid = 1'b1;
      wr_data  = 2'd2;
      tick();
      chk("bp_extra_count", 32'(count), 4);
      wr_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rd_addr = 2'(i);
         tick();
         chk("bp_read", 32'(rd_data), 32'(i));
      end

      // Restart after two words; the start-cycle word is discarded.
      start = 1'b1;
      tick();
      start    = 1'b0;
      wr_valid = 1'b1;
      wr_data  = 2'd3;
      tick();
      wr_data = 2'd1;
      tick();
      chk("rs_count2", 32'(count), 2);
      start   = 1'b1;
      wr_data = 2'd1;
      tick();
      start = 1'b0;
      chk("rs_count0", 32'(count), 0);
      chk("rs_busy",   32'(busy),  1);
      wr_data = 2'd2;
      tick();
      chk("rs_count1", 32'(count), 1);

      // Collision: write 2 to address 1 (holding 1) while reading address 1.
      rd_addr = 2'd1;
      wr_data = 2'd2;
      tick();
      chk("col_old", 32'(rd_data), 1);
      chk("col_count", 32'(count), 2);
      wr_valid = 1'b0;
      tick();
      chk("col_new", 32'(rd_data), 2);
      rd_addr = 2'd0;
      tick();
      chk("rs_read0", 32'(rd_data), 2);
      rd_addr = 2'd2;
      tick();
      chk("rs_read2_kept", 32'(rd_data), 2);
      rd_addr = 2'd3;
      tick();
      chk("rs_read3_kept", 32'(rd_data), 3);

      // Load 3,3,3,1 (checksum 2), then start clears it.
      start = 1'b1;
      tick();
      start = 1'b0;
`ifdef CONV_LOADER_CHECKSUM_EN
      chk("ck_cleared", 32'(checksum), 0);
`endif
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1;
         wr_data  = load_c[i];
         tick();
      end
      wr_valid = 1'b0;
      chk("ld3_done",  32'(done),  1);
      chk("ld3_count", 32'(count), 4);
`ifdef CONV_LOADER_CHECKSUM_EN
      chk("ld3_checksum", 32'(checksum), 2);
`endif
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ld4_count", 32'(count), 0);
      chk("ld4_done",  32'(done),  0);
`ifdef CONV_LOADER_CHECKSUM_EN
      chk("ld4_checksum", 32'(checksum), 0);
`endif

      // Reset mid-load aborts but keeps RAM contents.
      wr_valid = 1'b1;
      wr_data  = 2'd0;
      tick();
      reset_n  = 1'b0;
      wr_valid = 1'b0;
      tick();
      chk("ab_busy",  32'(busy),  0);
      chk("ab_count", 32'(count), 0);
      reset_n = 1'b1;
      rd_addr = 2'd3;
      tick();
      chk("ab_read3", 32'(rd_data), 1);
      rd_addr = 2'd0;
      tick();
      chk("ab_read0", 32'(rd_data), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_conv_table_loader
